// File: rtl/alu_issue_stage_pkg.sv
// Shared constants for the ALU issue stage: datapath width, ALU control codes,
// R-type function codes and alu_op encodings.
package alu_issue_stage_pkg;

    localparam int unsigned WORD = 8;

    typedef enum logic [3:0] {
        CTRL_AND = 4'b0000,
        CTRL_OR  = 4'b0001,
        CTRL_ADD = 4'b0010,
        CTRL_XOR = 4'b0011,
        CTRL_SUB = 4'b0110,
        CTRL_SLT = 4'b0111,
        CTRL_NOR = 4'b1100,
        CTRL_NOP = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ORI   = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

endpackage

// File: rtl/alu_issue_stage_alu_ctrl_dec.sv
// Combinational ALU control decoder: alu_op/funct -> 4-bit ALU ctrl,
// illegal flag and overflow-meaningful flag (add/sub only).
module alu_ctrl_dec
    import alu_issue_stage_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] ctrl_o,
    output logic       illegal_o,
    output logic       ovf_chk_o
);

    always_comb begin
        ctrl_o    = CTRL_NOP;
        illegal_o = 1'b0;
        ovf_chk_o = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: begin
                ctrl_o    = CTRL_ADD;
                ovf_chk_o = 1'b1;
            end
            ALUOP_SUB: begin
                ctrl_o    = CTRL_SUB;
                ovf_chk_o = 1'b1;
            end
            ALUOP_ORI: ctrl_o = CTRL_OR;
            default: begin
                case (funct_i)
                    FUNCT_ADD: begin
                        ctrl_o    = CTRL_ADD;
                        ovf_chk_o = 1'b1;
                    end
                    FUNCT_SUB: begin
                        ctrl_o    = CTRL_SUB;
                        ovf_chk_o = 1'b1;
                    end
                    FUNCT_AND: ctrl_o = CTRL_AND;
                    FUNCT_OR:  ctrl_o = CTRL_OR;
                    FUNCT_XOR: ctrl_o = CTRL_XOR;
                    FUNCT_NOR: ctrl_o = CTRL_NOR;
                    FUNCT_SLT: ctrl_o = CTRL_SLT;
                    default: begin
                        // NOP ctrl makes the ALU produce 0 for illegal ops
                        ctrl_o    = CTRL_NOP;
                        illegal_o = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage feeding a clocked ALU: S1 issue slot, S2 result slot aligned with
// the ALU's registered output. Optional result forwarding under ALU_ISSUE_FWD_EN.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned WIDTH = WORD,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       alu_op_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    input  logic [WIDTH-1:0] imm_i,
    input  logic             alu_src_i,
    input  logic [4:0]       rs_idx_i,
    input  logic [4:0]       rt_idx_i,
    input  logic [4:0]       rd_idx_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic [3:0]       alu_ctrl_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    input  logic [WIDTH-1:0] alu_result_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [TAG_W-1:0] res_tag_o,
    output logic             res_illegal_o,
    output logic             res_ovf_chk_o
);

    logic [3:0] dec_ctrl;
    logic       dec_illegal;
    logic       dec_ovf_chk;

    alu_ctrl_dec u_dec (
        .alu_op_i  (alu_op_i),
        .funct_i   (funct_i),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal),
        .ovf_chk_o (dec_ovf_chk)
    );

    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_ctrl_q, s1_ctrl_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [4:0]       s1_rd_q, s1_rd_d;
    logic             s1_illegal_q, s1_illegal_d;
    logic             s1_ovf_q, s1_ovf_d;

    logic             s2_valid_q, s2_valid_d;
    logic [3:0]       s2_ctrl_q, s2_ctrl_d;
    logic [WIDTH-1:0] s2_a_q, s2_a_d, s2_b_q, s2_b_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic [4:0]       s2_rd_q, s2_rd_d;
    logic             s2_illegal_q, s2_illegal_d;
    logic             s2_ovf_q, s2_ovf_d;

    logic             stall;
    logic             accept;
    logic [WIDTH-1:0] s1_a_drv, s1_b_drv;

    assign stall      = s2_valid_q & ~res_ready_i;
    assign in_ready_o = ~flush_i & (~s1_valid_q | ~stall);
    assign accept     = in_valid_i & in_ready_o;

`ifdef ALU_ISSUE_FWD_EN
    logic [4:0] s1_rs_q, s1_rs_d, s1_rt_q, s1_rt_d;
    logic       s1_use_rt_q, s1_use_rt_d;

    // S2's result is on alu_result_i while it sits in S2, so it can bypass the stale register read
    always_comb begin
        s1_a_drv = s1_a_q;
        s1_b_drv = s1_b_q;
        if (s2_valid_q && (s2_rd_q != '0)) begin
            if (s1_rs_q == s2_rd_q) s1_a_drv = alu_result_i;
            if (s1_use_rt_q && (s1_rt_q == s2_rd_q)) s1_b_drv = alu_result_i;
        end
    end

    always_comb begin
        s1_rs_d     = s1_rs_q;
        s1_rt_d     = s1_rt_q;
        s1_use_rt_d = s1_use_rt_q;
        if (!flush_i && accept) begin
            s1_rs_d     = rs_idx_i;
            s1_rt_d     = rt_idx_i;
            s1_use_rt_d = ~alu_src_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_rs_q     <= '0;
            s1_rt_q     <= '0;
            s1_use_rt_q <= 1'b0;
        end else begin
            s1_rs_q     <= s1_rs_d;
            s1_rt_q     <= s1_rt_d;
            s1_use_rt_q <= s1_use_rt_d;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{rs_idx_i, rt_idx_i, alu_result_i, s2_rd_q};
    assign s1_a_drv   = s1_a_q;
    assign s1_b_drv   = s1_b_q;
`endif

    // Under stall, replay S2 so the registered ALU output stays stable
    always_comb begin
        alu_ctrl_o = CTRL_NOP;
        alu_a_o    = '0;
        alu_b_o    = '0;
        if (stall) begin
            alu_ctrl_o = s2_ctrl_q;
            alu_a_o    = s2_a_q;
            alu_b_o    = s2_b_q;
        end else if (s1_valid_q) begin
            alu_ctrl_o = s1_ctrl_q;
            alu_a_o    = s1_a_drv;
            alu_b_o    = s1_b_drv;
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_ctrl_d    = s1_ctrl_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_tag_d     = s1_tag_q;
        s1_rd_d      = s1_rd_q;
        s1_illegal_d = s1_illegal_q;
        s1_ovf_d     = s1_ovf_q;
        s2_valid_d   = s2_valid_q;
        s2_ctrl_d    = s2_ctrl_q;
        s2_a_d       = s2_a_q;
        s2_b_d       = s2_b_q;
        s2_tag_d     = s2_tag_q;
        s2_rd_d      = s2_rd_q;
        s2_illegal_d = s2_illegal_q;
        s2_ovf_d     = s2_ovf_q;
        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (!stall) begin
                s2_valid_d   = s1_valid_q;
                s2_ctrl_d    = alu_ctrl_o;
                s2_a_d       = alu_a_o;
                s2_b_d       = alu_b_o;
                s2_tag_d     = s1_tag_q;
                s2_rd_d      = s1_rd_q;
                s2_illegal_d = s1_illegal_q;
                s2_ovf_d     = s1_ovf_q;
            end
            // An empty S1 may refill even while S2 is stalled
            if (accept) begin
                s1_valid_d   = 1'b1;
                s1_ctrl_d    = dec_ctrl;
                s1_a_d       = rs_data_i;
                s1_b_d       = alu_src_i ? imm_i : rt_data_i;
                s1_tag_d     = tag_i;
                s1_rd_d      = rd_idx_i;
                s1_illegal_d = dec_illegal;
                s1_ovf_d     = dec_ovf_chk;
            end else if (!stall) begin
                s1_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q   <= 1'b0;
            s1_ctrl_q    <= '0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_tag_q     <= '0;
            s1_rd_q      <= '0;
            s1_illegal_q <= 1'b0;
            s1_ovf_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_ctrl_q    <= '0;
            s2_a_q       <= '0;
            s2_b_q       <= '0;
            s2_tag_q     <= '0;
            s2_rd_q      <= '0;
            s2_illegal_q <= 1'b0;
            s2_ovf_q     <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_ctrl_q    <= s1_ctrl_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_tag_q     <= s1_tag_d;
            s1_rd_q      <= s1_rd_d;
            s1_illegal_q <= s1_illegal_d;
            s1_ovf_q     <= s1_ovf_d;
            s2_valid_q   <= s2_valid_d;
            s2_ctrl_q    <= s2_ctrl_d;
            s2_a_q       <= s2_a_d;
            s2_b_q       <= s2_b_d;
            s2_tag_q     <= s2_tag_d;
            s2_rd_q      <= s2_rd_d;
            s2_illegal_q <= s2_illegal_d;
            s2_ovf_q     <= s2_ovf_d;
        end
    end

    assign res_valid_o   = s2_valid_q;
    assign res_tag_o     = s2_valid_q ? s2_tag_q : '0;
    assign res_illegal_o = s2_valid_q & s2_illegal_q;
    assign res_ovf_chk_o = s2_valid_q & s2_ovf_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-issue stage directly upstream of the 8-bit ALU.
- Accepts decoded ops over a valid/ready handshake, decodes the 4-bit ALU control, selects operands (register or immediate) and drives ctrl/A/B into the clocked ALU.
- Tracks each op through the ALU's one-cycle registered result and presents res_valid/tag/flags to writeback, with backpressure, flush and optional result forwarding.

Parameters:
- WIDTH, 8, datapath width (matches `WORD).
- TAG_W, 4, width of the op tag carried alongside each op.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  upstream op valid.
- in_ready_o  out  1  stage accepts op this cycle.
- alu_op_i  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or-immediate.
- funct_i  in  6  R-type function code.
- rs_data_i, rt_data_i  in  WIDTH  register operands.
- imm_i  in  WIDTH  immediate operand.
- alu_src_i  in  1  1: B = imm_i, 0: B = rt_data_i.
- rs_idx_i, rt_idx_i, rd_idx_i  in  5  register indices (used only with forwarding).
- tag_i  in  TAG_W  op tag.
- flush_i  in  1  synchronous kill of all in-flight ops.
- alu_ctrl_o  out  4  to ALU ctrl.
- alu_a_o, alu_b_o  out  WIDTH  to ALU A/B.
- alu_result_i  in  WIDTH  ALU outALU fed back (forwarding only).
- res_valid_o  out  1  ALU output currently holds a tracked result.
- res_ready_i  in  1  writeback consumes result.
- res_tag_o  out  TAG_W  tag of the result.
- res_illegal_o  out  1  op decoded as illegal.
- res_ovf_chk_o  out  1  op was add/sub; ALU overflow is meaningful.

Behaviour:
- Decode: alu_op 00 -> 0010, 01 -> 0110, 11 -> 0001.
- R-type funct: 0x20 -> 0010, 0x22 -> 0110, 0x24 -> 0000, 0x25 -> 0001, 0x26 -> 0011, 0x27 -> 1100, 0x2A -> 0111.
- Any other funct -> ctrl 1111 with illegal = 1; the ALU yields 0.
- Two registered slots:
  - S1 (issue): valid, ctrl, A, B, tag, rd, illegal, ovf_chk.
  - S2 (result): same fields, aligned with the ALU's registered output.
- Stall condition: stall = s2_valid & ~res_ready_i.
- ALU drive (combinational):
  - If stall, drive S2's stored ctrl/A/B (replay) so the ALU output stays stable.
  - Otherwise drive S1's fields, forwarded if enabled.
- Handshake: in_ready_o = ~flush_i & (~s1_valid | ~stall).
- Rising edge, not stall and not flush:
  - S2 <= S1, storing the operand values actually driven.
  - S1 <= input if in_valid_i & in_ready_o, else s1_valid <= 0.
- Rising edge with stall: S1 and S2 hold.
- flush_i has priority: s1_valid and s2_valid <= 0 at the edge, and input is not accepted.
- Outputs:
  - res_valid_o = s2_valid.
  - res_tag_o, res_illegal_o, res_ovf_chk_o come from S2.
- Latency: op accepted at edge E0 -> ALU samples at E1 -> res_valid_o high after E1.
- Throughput: 1 op/cycle with res_ready_i held high.
- Empty S1 while not stalled: drive ctrl 1111 (ALU outputs 0, no false result). S2 then goes invalid next edge.
- Reset (async, rst_ni low):
  - s1_valid, s2_valid = 0; all stored fields = 0.
  - alu_ctrl_o = 1111, alu_a_o = alu_b_o = 0.
  - res_* = 0; in_ready_o = 1 once flush_i is low.
- Reset mid-operation drops all in-flight ops with no result emitted.

Optional Feature:
- ALU_ISSUE_FWD_EN defined:
  - When not stalled, s2_valid and S2.rd != 0:
    - S1.rs == S2.rd -> A = alu_result_i.
    - ~alu_src & S1.rt == S2.rd -> B = alu_result_i.
  - S1 captures rs/rt indices at accept.
- Undefined: index and alu_result_i ports exist but are ignored; A/B always come from captured register data.

Decomposition:
- Shared include lagartoII_const.vh holds:
  - ALU ctrl codes (AND/OR/XOR/ADD/SUB/SLT/NOR/NOP=1111).
  - funct codes, alu_op encodings.
  - `WORD.
- One natural combinational sub-module: alu_ctrl_dec (alu_op, funct -> ctrl, illegal, ovf_chk).

Test Plan:
- Reset low mid-stream -> all valid flags 0, alu_ctrl_o = 1111, in_ready_o = 1 after release.
- Back-to-back R-type add 5+3 (0x20) then sub 9-4 (0x22), res_ready_i = 1 -> ctrl 0010, then 0110; res_valid_o 2 edges after each accept; tags 1, 2 in order.
- funct 0x3F -> ctrl 1111, res_illegal_o = 1, ALU result 0.
- res_ready_i low 3 cycles with result 8 in S2 and next op queued -> alu_a/b/ctrl replay S2; in_ready_o = 0; res_tag_o and result stable; resumes without loss or duplication.
- flush_i with both slots valid -> res_valid_o = 0 next cycle; the op offered during flush is not accepted.
- ALU_ISSUE_FWD_EN: add r3 = 2+2 then add r4 = r3 + 1 with stale r3 = 0 -> second A = 4, result 5; without the macro the result is 1.
